id_stage: RTL and testbench

- Instruction-decode stage; sits between the IF/ID pipeline register and the ID/EX stage register, and drives every input of that register.
- Holds the 4x64-bit register file and decodes the 32-bit instruction into the control fields.
- Has no forwarding network, so it detects RAW hazards, stalls the front end and injects bubbles.
- Keeps a stall-cycle performance counter.

---
 rtl/id_stage.sv | 137 +++++++++++++
 tb/tb_id_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, control decode, RAW hazard
// detection with bubble injection, and a saturating stall-cycle counter.
module id_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [1:0]        ex_rd,
  input  logic              ex_wreg,
  input  logic [1:0]        mem_rd,
  input  logic              mem_wreg,
  input  logic [1:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_en,
  output logic [DATA_W-1:0] rs_data_out,
  output logic [DATA_W-1:0] rt_data_out,
  output logic [1:0]        rd_out,
  output logic [7:0]        address_out,
  output logic              WRegEn_out,
  output logic              WMemEn_out,
  output logic              MemToReg_out,
  output logic [3:0]        ALUOp_out,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  logic [DATA_W-1:0] regs_q [4];
  logic [CNT_W-1:0]  stall_count_q;

  logic [3:0] op;
  logic [1:0] rs, rt, rd;
  logic [7:0] addr;

  logic       dec_wreg, dec_wmem, dec_m2r;
  logic [3:0] dec_alu;
  logic       uses_rs, uses_rt;

  logic [DATA_W-1:0] rs_val, rt_val;
  logic              rs_busy, rt_busy;
  logic              bubble;

  assign op   = instr[31:28];
  assign rs   = instr[27:26];
  assign rt   = instr[25:24];
  assign rd   = instr[23:22];
  assign addr = instr[7:0];

  // Opcode decode into control fields and source-usage flags.
  always_comb begin
    dec_wreg = 1'b0;
    dec_wmem = 1'b0;
    dec_m2r  = 1'b0;
    dec_alu  = 4'd0;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        dec_wreg = 1'b1;
        dec_alu  = op;
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
      end
      4'd8: begin
        dec_wreg = 1'b1;
        dec_m2r  = 1'b1;
      end
      4'd9: begin
        dec_wmem = 1'b1;
        uses_rt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file reads with write-through bypass from the write-back port.
  always_comb begin
    rs_val = (wb_en && (wb_rd == rs)) ? wb_data : regs_q[rs];
    rt_val = (wb_en && (wb_rd == rt)) ? wb_data : regs_q[rt];
  end

  // RAW hazard against EX and MEM only; write-back is covered by the bypass.
  always_comb begin
    rs_busy = (ex_wreg && (ex_rd == rs)) || (mem_wreg && (mem_rd == rs));
    rt_busy = (ex_wreg && (ex_rd == rt)) || (mem_wreg && (mem_rd == rt));
    stall   = instr_valid && !reset && ((uses_rs && rs_busy) || (uses_rt && rt_busy));
    bubble  = stall || !instr_valid || reset;
  end

  // Drive the ID/EX inputs, forcing a bubble when stalled, invalid or in reset.
  always_comb begin
    rs_data_out  = '0;
    rt_data_out  = '0;
    rd_out       = 2'd0;
    address_out  = 8'd0;
    WRegEn_out   = 1'b0;
    WMemEn_out   = 1'b0;
    MemToReg_out = 1'b0;
    ALUOp_out    = 4'd0;
    if (!bubble) begin
      rs_data_out  = rs_val;
      rt_data_out  = rt_val;
      WRegEn_out   = dec_wreg;
      WMemEn_out   = dec_wmem;
      MemToReg_out = dec_m2r;
      ALUOp_out    = dec_alu;
      // rd/address only meaningful for ops that consume them; NOPs present zeros.
      if (dec_wreg || dec_wmem) begin
        rd_out      = rd;
        address_out = addr;
      end
    end
  end

  // Register file write port; reset takes priority over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: driver pushes reference-model expectations,
// monitor pops and compares on the falling edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_wreg, mem_wreg, wb_en;
  logic [63:0] wb_data;

  logic [63:0] rs_data_out, rt_data_out;
  logic [1:0]  rd_out;
  logic [7:0]  address_out;
  logic        WRegEn_out, WMemEn_out, MemToReg_out, stall;
  logic [3:0]  ALUOp_out;
  logic [31:0] stall_count;

  logic [63:0] s_rs, s_rt;
  logic [1:0]  s_rd;
  logic [7:0]  s_addr;
  logic        s_wreg, s_wmem, s_m2r, s_stall;
  logic [3:0]  s_alu;
  logic [3:0]  s_count;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .ex_rd(ex_rd), .ex_wreg(ex_wreg), .mem_rd(mem_rd), .mem_wreg(mem_wreg),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_en(wb_en),
    .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .rd_out(rd_out),
    .address_out(address_out), .WRegEn_out(WRegEn_out), .WMemEn_out(WMemEn_out),
    .MemToReg_out(MemToReg_out), .ALUOp_out(ALUOp_out), .stall(stall),
    .stall_count(stall_count)
  );

  // Narrow-counter copy to exercise saturation.
  id_stage #(.DATA_W(64), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .ex_rd(ex_rd), .ex_wreg(ex_wreg), .mem_rd(mem_rd), .mem_wreg(mem_wreg),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_en(wb_en),
    .rs_data_out(s_rs), .rt_data_out(s_rt), .rd_out(s_rd),
    .address_out(s_addr), .WRegEn_out(s_wreg), .WMemEn_out(s_wmem),
    .MemToReg_out(s_m2r), .ALUOp_out(s_alu), .stall(s_stall),
    .stall_count(s_count)
  );

  typedef struct {
    logic [63:0] rs_d;
    logic [63:0] rt_d;
    logic [1:0]  rd;
    logic [7:0]  addr;
    logic        wreg;
    logic        wmem;
    logic        m2r;
    logic [3:0]  alu;
    logic        stall;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [63:0] m_regs [4];
  longint unsigned m_cnt;
  int unsigned     m_cnt4;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd,
                                     input int addr);
    logic [31:0] w;
    w = '0;
    w[31:28] = 4'(op);
    w[27:26] = 2'(rs);
    w[25:24] = 2'(rt);
    w[23:22] = 2'(rd);
    w[7:0]   = 8'(addr);
    return w;
  endfunction

  // Compute expectation from current inputs, push it, advance the model over the edge.
  task automatic cyc();
    exp_t e;
    int op;
    bit alu_op, is_ld, is_st, use_rs, use_rt, haz, nop;
    int rs, rt;
    op = int'(instr[31:28]);
    rs = int'(instr[27:26]);
    rt = int'(instr[25:24]);
    alu_op = (op >= 1) && (op <= 7);
    is_ld  = (op == 8);
    is_st  = (op == 9);
    use_rs = alu_op;
    use_rt = alu_op || is_st;
    haz = instr_valid && !reset &&
          ((use_rs && ((ex_wreg && int'(ex_rd) == rs) || (mem_wreg && int'(mem_rd) == rs))) ||
           (use_rt && ((ex_wreg && int'(ex_rd) == rt) || (mem_wreg && int'(mem_rd) == rt))));
    nop = haz || !instr_valid || reset;
    e.stall = haz;
    e.cnt   = 32'(m_cnt);
    e.cnt4  = 4'(m_cnt4);
    if (nop || !(alu_op || is_ld || is_st)) begin
      e.wreg = 0; e.wmem = 0; e.m2r = 0; e.alu = 0; e.rd = 0; e.addr = 0;
    end else begin
      e.wreg = alu_op || is_ld;
      e.wmem = is_st;
      e.m2r  = is_ld;
      e.alu  = alu_op ? 4'(op) : 4'd0;
      e.rd   = instr[23:22];
      e.addr = instr[7:0];
    end
    if (nop) begin
      e.rs_d = 0; e.rt_d = 0;
    end else begin
      e.rs_d = (wb_en && int'(wb_rd) == rs) ? wb_data : m_regs[rs];
      e.rt_d = (wb_en && int'(wb_rd) == rt) ? wb_data : m_regs[rt];
    end
    q.push_back(e);
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_cnt = 0;
      m_cnt4 = 0;
    end else begin
      if (wb_en) m_regs[wb_rd] = wb_data;
      if (haz) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 0; instr = 0; instr_valid = 0;
    ex_rd = 0; ex_wreg = 0; mem_rd = 0; mem_wreg = 0;
    wb_rd = 0; wb_data = 0; wb_en = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each driven cycle is a presented result.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs_data", rs_data_out, e.rs_d);
      chk("rt_data", rt_data_out, e.rt_d);
      chk("rd", 64'(rd_out), 64'(e.rd));
      chk("address", 64'(address_out), 64'(e.addr));
      chk("WRegEn", 64'(WRegEn_out), 64'(e.wreg));
      chk("WMemEn", 64'(WMemEn_out), 64'(e.wmem));
      chk("MemToReg", 64'(MemToReg_out), 64'(e.m2r));
      chk("ALUOp", 64'(ALUOp_out), 64'(e.alu));
      chk("stall", 64'(stall), 64'(e.stall));
      chk("stall_count", 64'(stall_count), 64'(e.cnt));
      chk("stall_count_sat", 64'(s_count), 64'(e.cnt4));
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_cnt = 0;
    m_cnt4 = 0;
    quiet();
    @(posedge clk);
    #1;

    // Reset then decode
    reset = 1; cyc(); cyc();
    reset = 0; instr_valid = 1; instr = mk(1, 1, 2, 3, 0); cyc();

    // Write-back with same-cycle bypass, then plain read
    wb_en = 1; wb_rd = 2; wb_data = 64'h1234; instr = mk(2, 2, 0, 1, 0); cyc();
    wb_en = 0; cyc();

    // RAW from EX
    ex_rd = 1; ex_wreg = 1; instr = mk(5, 1, 2, 0, 0); cyc(); cyc();
    ex_wreg = 0; cyc();

    // Unused source field
    ex_rd = 0; ex_wreg = 1; instr = mk(8, 0, 0, 2, 8'h5A); cyc();
    ex_wreg = 0;

    // STORE hazard on rt only
    mem_rd = 3; mem_wreg = 1; instr = mk(9, 0, 3, 0, 8'h11); cyc();
    instr = mk(9, 3, 0, 0, 8'h22); cyc();
    mem_wreg = 0;

    // Preload, reset during a stall, read back zeros
    instr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wb_en = 1; wb_rd = 2'(i); wb_data = {$urandom, $urandom}; cyc();
    end
    wb_en = 0; instr_valid = 1; ex_rd = 0; ex_wreg = 1; instr = mk(1, 0, 1, 1, 0); cyc();
    reset = 1; wb_en = 1; wb_rd = 1; wb_data = 64'hDEAD; cyc();
    reset = 0; wb_en = 0; ex_wreg = 0; cyc();
    instr = mk(1, 2, 3, 2, 0); cyc();

    // Saturation on the 4-bit counter
    ex_rd = 2; ex_wreg = 1; instr = mk(3, 2, 2, 0, 0);
    for (int i = 0; i < 20; i++) cyc();
    ex_wreg = 0; cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      instr       = $urandom;
      instr_valid = ($urandom_range(0, 7) != 0);
      ex_rd       = 2'($urandom);
      ex_wreg     = 1'($urandom);
      mem_rd      = 2'($urandom);
      mem_wreg    = 1'($urandom);
      wb_rd       = 2'($urandom);
      wb_en       = 1'($urandom);
      wb_data     = {$urandom, $urandom};
      cyc();
    end

    quiet();
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
